// File: rtl/ram_arb_pkg.sv
// ---------------------------------------------------------------------------
// ram_arb_pkg
// Shared types and helpers for the two-port RAM arbiter.
//   - obi_req_t / obi_rsp_t : OBI-style request / response bundles at the
//     default 22-bit address / 32-bit data geometry of the wrapper RAM.
//   - PORT_IFETCH / PORT_DATA : port indices (0 = instruction fetch,
//     1 = data/LSU), used to index the one-hot grant vector.
//   - arb_grant() : pure arbitration decision, returns a one-hot grant.
// ---------------------------------------------------------------------------
package ram_arb_pkg;

  localparam int ARB_ADDR_WIDTH = 22;
  localparam int ARB_DATA_WIDTH = 32;

  localparam int PORT_IFETCH = 0;
  localparam int PORT_DATA   = 1;

  typedef struct packed {
    logic                          req;
    logic [ARB_ADDR_WIDTH-1:0]     addr;
    logic                          we;
    logic [ARB_DATA_WIDTH/8-1:0]   be;
    logic [ARB_DATA_WIDTH-1:0]     wdata;
  } obi_req_t;

  typedef struct packed {
    logic                      gnt;
    logic                      rvalid;
    logic [ARB_DATA_WIDTH-1:0] rdata;
  } obi_rsp_t;

  // One-hot grant: bit PORT_IFETCH / bit PORT_DATA.
  // On a conflict, round-robin hands the access to the port that did not
  // win last time; fixed priority always favours the data port.
  function automatic logic [1:0] arb_grant(input logic req0,
                                           input logic req1,
                                           input logic last_gnt,
                                           input logic fixed_prio);
    logic [1:0] g;
    g = 2'b00;
    if (req0 && req1) begin
      if (fixed_prio || !last_gnt) g = 2'b10;
      else                         g = 2'b01;
    end else if (req0) begin
      g = 2'b01;
    end else if (req1) begin
      g = 2'b10;
    end
    return g;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the arbiter performance statistics.
// Sticks at all-ones instead of wrapping so a long run never reports a
// misleadingly small count.
//   clk_i    in   clock
//   rst_ni   in   async active-low reset, clears the count
//   inc_i    in   increment request for this cycle
//   count_o  out  current count (CNT_WIDTH bits)
// ---------------------------------------------------------------------------
module sat_counter #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 inc_i,
  output logic [CNT_WIDTH-1:0] count_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [CNT_WIDTH-1:0] r_count;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_count <= '0;
    end else if (inc_i && (r_count != CNT_MAX)) begin
      r_count <= r_count + CNT_ONE;
    end
  end

  assign count_o = r_count;

endmodule

// File: rtl/ram_port_arbiter.sv
// ---------------------------------------------------------------------------
// ram_port_arbiter
// Shares one single-port synchronous RAM (1-cycle read latency) between the
// core instruction-fetch port (m0) and the data/LSU port (m1).
//
// Handshake: a requester raises mN_req_i with stable addr/we/be/wdata and
// holds it until mN_gnt_o is seen high in the same cycle; a grant is an
// accepted transfer and is never revoked. Exactly one mN_rvalid_o pulse
// follows each grant one cycle later (reads and writes alike); rvalid has no
// ready and cannot be stalled, so back-to-back grants give back-to-back
// responses.
//
// Ports
//   clk_i, rst_ni               clock, async active-low reset
//   mN_req/addr/we/be/wdata_i   request from port N (N = 0 ifetch, 1 data)
//   mN_gnt_o                    request accepted this cycle
//   mN_rvalid_o, mN_rdata_o     response; rdata = 0 for writes / non-owner
//   ram_en/addr/we/be/wdata_o   RAM access (all zero when idle)
//   ram_rdata_i                 RAM read data, valid cycle after ram_en_o
//   gnt_cnt0_o, gnt_cnt1_o      saturating grant counts per port
//   conflict_cnt_o              saturating count of both-request cycles
// ---------------------------------------------------------------------------
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 22,
  parameter int DATA_WIDTH = 32,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  // port 0: instruction fetch
  input  logic                    m0_req_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic                    m0_we_i,
  input  logic [DATA_WIDTH/8-1:0] m0_be_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  output logic                    m0_gnt_o,
  output logic                    m0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  // port 1: data / LSU
  input  logic                    m1_req_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic                    m1_we_i,
  input  logic [DATA_WIDTH/8-1:0] m1_be_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  output logic                    m1_gnt_o,
  output logic                    m1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  // RAM side
  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,
  // performance counters
  output logic [CNT_WIDTH-1:0]    gnt_cnt0_o,
  output logic [CNT_WIDTH-1:0]    gnt_cnt1_o,
  output logic [CNT_WIDTH-1:0]    conflict_cnt_o
);

  localparam logic W_FIXED = (FIXED_PRIO != 0);

  // Arbitration state and response tracking
  logic       r_last_gnt;   // port that won the most recent grant
  logic       r_rsp_valid;  // a response is due this cycle
  logic       r_rsp_owner;  // port that owns the pending response
  logic       r_rsp_we;     // pending response belongs to a write

  logic [1:0] w_gnt;
  logic       w_any_gnt;
  logic       w_conflict;
  logic       w_win_we;

  assign w_gnt      = arb_grant(m0_req_i, m1_req_i, r_last_gnt, W_FIXED);
  assign w_any_gnt  = |w_gnt;
  assign w_conflict = m0_req_i & m1_req_i;
  assign w_win_we   = w_gnt[PORT_DATA] ? m1_we_i : m0_we_i;

  assign m0_gnt_o = w_gnt[PORT_IFETCH];
  assign m1_gnt_o = w_gnt[PORT_DATA];

  // RAM request mux: zero when idle so the RAM side never sees stale data.
  always_comb begin
    ram_en_o    = w_any_gnt;
    ram_addr_o  = '0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_wdata_o = '0;
    if (w_gnt[PORT_DATA]) begin
      ram_addr_o  = m1_addr_i;
      ram_we_o    = m1_we_i;
      ram_be_o    = m1_be_i;
      ram_wdata_o = m1_wdata_i;
    end else if (w_gnt[PORT_IFETCH]) begin
      ram_addr_o  = m0_addr_i;
      ram_we_o    = m0_we_i;
      ram_be_o    = m0_be_i;
      ram_wdata_o = m0_wdata_i;
    end
  end

  // last_gnt resets to the data port so the first conflict goes to ifetch.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last_gnt  <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_owner <= 1'b0;
      r_rsp_we    <= 1'b0;
    end else begin
      r_rsp_valid <= w_any_gnt;
      if (w_any_gnt) begin
        r_last_gnt  <= w_gnt[PORT_DATA];
        r_rsp_owner <= w_gnt[PORT_DATA];
        r_rsp_we    <= w_win_we;
      end
    end
  end

  // Response routing: the pending response is independent of any grant
  // issued in the same cycle, which is what gives full pipeline overlap.
  assign m0_rvalid_o = r_rsp_valid & ~r_rsp_owner;
  assign m1_rvalid_o = r_rsp_valid &  r_rsp_owner;
  assign m0_rdata_o  = (m0_rvalid_o && !r_rsp_we) ? ram_rdata_i : '0;
  assign m1_rdata_o  = (m1_rvalid_o && !r_rsp_we) ? ram_rdata_i : '0;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_gnt_cnt0 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (w_gnt[PORT_IFETCH]),
    .count_o (gnt_cnt0_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_gnt_cnt1 (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (w_gnt[PORT_DATA]),
    .count_o (gnt_cnt1_o)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_conflict_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .inc_i   (w_conflict),
    .count_o (conflict_cnt_o)
  );

endmodule
